apple_spawn_scanner: RTL

APPLE_SPAWN_SCANNER -- requirements
Module: apple_spawn_scanner

---
 rtl/apple_spawn_scanner.sv | 125 ++++++++++++
 1 files changed

// File: rtl/apple_spawn_scanner.sv
// apple_spawn_scanner: picks a random in-bounds apple position that does not overlap the snake
module apple_spawn_scanner #(
  parameter int SegWidth        = 10,
  parameter int SegHeight       = 10,
  parameter int AppleWidth      = 10,
  parameter int AppleHeight     = 10,
  parameter int BorderThickness = 10,
  parameter int DisplayWidth    = 240,
  parameter int DisplayHeight   = 320,
  parameter int XWidth          = 8,
  parameter int YWidth          = 9,
  parameter int MaxSegments     = 128,
  parameter int MaxTries        = 16,
  parameter int ResetAppleX     = 100,
  parameter int ResetAppleY     = 150
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [MaxSegments*XWidth-1:0] snakeLocX,
  input  logic [MaxSegments*YWidth-1:0] snakeLocY,
  input  logic [7:0]                    size,
  input  logic                          spawnReq,
  input  logic                          forceCand,
  input  logic [XWidth-1:0]             forceX,
  input  logic [YWidth-1:0]             forceY,
  output logic [XWidth-1:0]             appleLocX,
  output logic [YWidth-1:0]             appleLocY,
  output logic                          appleValid,
  output logic                          spawnFail,
  output logic                          busy
);
  localparam int CW = (XWidth > YWidth ? XWidth : YWidth) + 2;
  localparam int IW = $clog2(MaxSegments + 1);
  localparam int TW = $clog2(MaxTries + 1);
  typedef enum logic [2:0] {IDLE, GEN, SCAN, DONE, FAIL} state_t;
  state_t state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [TW-1:0] try_q, try_d, try_inc;
  logic [IW-1:0] idx_q, idx_d, n;
  logic [XWidth-1:0] cand_x_q, cand_x_d, apple_x_q, apple_x_d, gen_x, seg_x;
  logic [YWidth-1:0] cand_y_q, cand_y_d, apple_y_q, apple_y_d, gen_y, seg_y;
  logic valid_q, valid_d, fail_q, fail_d;
  logic in_bounds, hit, last, reject;
  assign n = (32'(size) > 32'(MaxSegments)) ? IW'(MaxSegments) : IW'(size);
  assign gen_x = forceCand ? forceX : lfsr_q[XWidth-1:0];
  assign gen_y = forceCand ? forceY : lfsr_q[15 -: YWidth];
  assign seg_x = snakeLocX[idx_q*XWidth +: XWidth];
  assign seg_y = snakeLocY[idx_q*YWidth +: YWidth];
  assign in_bounds = 32'(gen_x) >= 32'(BorderThickness) &&
                     32'(gen_x) <= 32'(DisplayWidth - BorderThickness - AppleWidth) &&
                     32'(gen_y) >= 32'(BorderThickness) &&
                     32'(gen_y) <= 32'(DisplayHeight - BorderThickness - AppleHeight);
  assign hit = CW'(cand_x_q) < CW'(seg_x) + CW'(SegWidth) &&
               CW'(seg_x) < CW'(cand_x_q) + CW'(AppleWidth) &&
               CW'(cand_y_q) < CW'(seg_y) + CW'(SegHeight) &&
               CW'(seg_y) < CW'(cand_y_q) + CW'(AppleHeight);
  assign last = idx_q == n - 1'b1;
  assign try_inc = try_q + 1'b1;
  assign reject = (state_q == GEN && !in_bounds) || (state_q == SCAN && hit);
  assign appleLocX = apple_x_q;
  assign appleLocY = apple_y_q;
  assign appleValid = valid_q;
  assign spawnFail = fail_q;
  assign busy = state_q != IDLE;
  // Next-state: latch candidate in GEN, walk segments in SCAN, retry or give up on rejection
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    state_d = state_q;
    try_d = try_q;
    idx_d = idx_q;
    cand_x_d = cand_x_q;
    cand_y_d = cand_y_q;
    apple_x_d = state_q == DONE ? cand_x_q : apple_x_q;
    apple_y_d = state_q == DONE ? cand_y_q : apple_y_q;
    valid_d = state_q == DONE;
    fail_d = state_q == FAIL;
    case (state_q)
      IDLE: begin
        try_d = spawnReq ? '0 : try_q;
        state_d = spawnReq ? GEN : IDLE;
      end
      GEN: begin
        cand_x_d = gen_x;
        cand_y_d = gen_y;
        idx_d = '0;
        state_d = n == '0 ? DONE : SCAN;
      end
      SCAN: begin
        idx_d = idx_q + 1'b1;
        state_d = last ? DONE : SCAN;
      end
      default: state_d = IDLE;
    endcase
    if (reject) begin
      try_d = try_inc;
      state_d = try_inc == TW'(MaxTries) ? FAIL : GEN;
    end
  end
  // State and output registers; reset aborts any search without a completion pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      lfsr_q <= 16'hACE1;
      try_q <= '0;
      idx_q <= '0;
      cand_x_q <= '0;
      cand_y_q <= '0;
      apple_x_q <= XWidth'(ResetAppleX);
      apple_y_q <= YWidth'(ResetAppleY);
      valid_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      try_q <= try_d;
      idx_q <= idx_d;
      cand_x_q <= cand_x_d;
      cand_y_q <= cand_y_d;
      apple_x_q <= apple_x_d;
      apple_y_q <= apple_y_d;
      valid_q <= valid_d;
      fail_q <= fail_d;
    end
  end
endmodule
